stopwatch_ctrl: RTL and testbench

//   Sequencing controller for a chain of BCD decade counters (0..9 per digit).
//   - Runs a start/pause/clear state machine.
//   - Divides clk into count ticks with a prescaler.
//   - Ripples carries across DIGITS decade stages.
//   - Top-level timing block for the tutorial counter designs; drives the display digits.
//

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/bcd_digit.sv | 35 +++
 rtl/stopwatch_ctrl.sv | 133 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD digit stages.
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVF   = 2'd3
  } state_e;

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    return (v == BCD_MAX) ? '0 : v + BCD_W'(1);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD decade stage (0..9) with synchronous clear and a combinational carry-out.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             co
);

  logic [BCD_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = bcd_inc(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign co = inc & (q_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/pause/clear FSM, prescaler, BCD carry chain and saturation.
// Optional lap-hold display snapshot is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_stop,
  input  logic                    clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic                    lap,
`endif
  output logic [BCD_W*DIGITS-1:0] digits,
  output logic                    running,
  output logic                    overflow
);

  localparam int unsigned PW = $clog2(PRESCALE);

  state_e                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic                    running_q, running_d;
  logic                    overflow_q, overflow_d;
  logic [BCD_W*DIGITS-1:0] live;
  logic [DIGITS:0]         carry;
  logic                    tick;
  logic                    all_nine;
  logic                    unused_top_co;

  assign tick = (state_q == ST_RUN) && (presc_q == PW'(PRESCALE - 1));

  always_comb begin
    all_nine = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (live[i*BCD_W +: BCD_W] != BCD_MAX) all_nine = 1'b0;
    end
  end

  // Saturation: an all-9 tick never reaches the chain, so the count holds at 9..9.
  assign carry[0] = tick & ~all_nine;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : gen_digit
    bcd_digit u_digit (
      .clk (clk),
      .rst (rst),
      .clr (clear),
      .inc (carry[g]),
      .q   (live[g*BCD_W +: BCD_W]),
      .co  (carry[g+1])
    );
  end

  assign unused_top_co = carry[DIGITS];

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start_stop) state_d = ST_RUN;
        ST_RUN: begin
          if (tick && all_nine) begin
            state_d = ST_OVF;
          end else if (start_stop) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: if (start_stop) state_d = ST_RUN;
        ST_OVF:   ;
        default:  state_d = ST_IDLE;
      endcase
    end
    running_d  = (state_d == ST_RUN);
    overflow_d = (state_d == ST_OVF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
    end
  end

  assign running  = running_q;
  assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic                    hold_q, hold_d;
  logic [BCD_W*DIGITS-1:0] snap_q, snap_d;

  always_comb begin
    hold_d = hold_q;
    snap_d = snap_q;
    if (clear) begin
      hold_d = 1'b0;
    end else if (lap && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
      hold_d = ~hold_q;
      if (!hold_q) snap_d = live;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else begin
      hold_q <= hold_d;
      snap_q <= snap_d;
    end
  end

  assign digits = hold_q ? snap_q : live;
`else
  assign digits = live;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (DIGITS=2, PRESCALE=2): stimulus queues expected
// outputs tagged with a cycle number; the monitor compares them on the falling edge.
module tb_stopwatch_ctrl;

  localparam int unsigned DIGITS   = 2;
  localparam int unsigned PRESCALE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] digits;
  logic       running;
  logic       overflow;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic       lap = 1'b0;
`endif

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap        (lap),
`endif
    .digits     (digits),
    .running    (running),
    .overflow   (overflow)
  );

  typedef struct {
    int         cyc;
    logic [7:0] dig;
    logic       run;
    logic       ovf;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected state after the edge that is dly cycles ahead of the current one.
  task automatic expect_in(input int dly, input string name, input logic [7:0] dig,
                           input logic run, input logic ovf);
    exp_t e;
    e.cyc  = cyc + dly;
    e.dig  = dig;
    e.run  = run;
    e.ovf  = ovf;
    e.name = name;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        if (digits !== sb[i].dig || running !== sb[i].run || overflow !== sb[i].ovf) begin
          failures++;
          $display("FAIL %s: got digits=%h running=%b overflow=%b, want digits=%h running=%b overflow=%b",
                   sb[i].name, digits, running, overflow, sb[i].dig, sb[i].run, sb[i].ovf);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    step(2);
    expect_in(0, "reset", 8'h00, 1'b0, 1'b0);
    checks++;
    if (digits !== 8'h00 || running !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_direct: got digits=%h running=%b overflow=%b, want digits=00 running=0 overflow=0",
               digits, running, overflow);
    end
    rst = 1'b0;
    step(1);

    // Carry ripple: 09 -> 10 in one edge
    pulse_ss();
    expect_in(0,  "start",      8'h00, 1'b1, 1'b0);
    expect_in(1,  "presc_wait", 8'h00, 1'b1, 1'b0);
    expect_in(2,  "first_tick", 8'h01, 1'b1, 1'b0);
    expect_in(18, "pre_carry",  8'h09, 1'b1, 1'b0);
    expect_in(19, "carry_hold", 8'h09, 1'b1, 1'b0);
    expect_in(20, "carry",      8'h10, 1'b1, 1'b0);
    step(20);
    pulse_clr();
    expect_in(0, "clear_run", 8'h00, 1'b0, 1'b0);

    // Pause mid-period, resume finishes the remaining prescaler cycle
    pulse_ss();
    step(10);
    expect_in(0, "pre_pause", 8'h05, 1'b1, 1'b0);
    pulse_ss();
    expect_in(0,  "pause",      8'h05, 1'b0, 1'b0);
    expect_in(10, "pause_hold", 8'h05, 1'b0, 1'b0);
    step(10);
    pulse_ss();
    expect_in(0, "resume",      8'h05, 1'b1, 1'b0);
    expect_in(1, "resume_tick", 8'h06, 1'b1, 1'b0);
    step(1);
    pulse_clr();

    // Saturation into OVF; start_stop ignored there
    pulse_ss();
    expect_in(198, "pre_ovf",      8'h99, 1'b1, 1'b0);
    expect_in(199, "pre_ovf_hold", 8'h99, 1'b1, 1'b0);
    expect_in(200, "ovf",          8'h99, 1'b0, 1'b1);
    step(200);
    checks++;
    if (digits !== 8'h99 || running !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_direct: got digits=%h running=%b overflow=%b, want digits=99 running=0 overflow=1",
               digits, running, overflow);
    end
    pulse_ss();
    expect_in(0, "ovf_ignore_ss", 8'h99, 1'b0, 1'b1);
    expect_in(3, "ovf_hold",      8'h99, 1'b0, 1'b1);
    step(3);
    pulse_clr();
    expect_in(0, "ovf_clear", 8'h00, 1'b0, 1'b0);
    checks++;
    if (digits !== 8'h00 || running !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear_direct: got digits=%h running=%b overflow=%b, want digits=00 running=0 overflow=0",
               digits, running, overflow);
    end
    pulse_ss();
    expect_in(0, "idle_after_ovf", 8'h00, 1'b1, 1'b0);
    pulse_clr();

    // clear beats start_stop; rst mid-run
    pulse_ss();
    step(4);
    expect_in(0, "pre_prio", 8'h02, 1'b1, 1'b0);
    clear      = 1'b1;
    start_stop = 1'b1;
    step(1);
    clear      = 1'b0;
    start_stop = 1'b0;
    expect_in(0, "prio",      8'h00, 1'b0, 1'b0);
    expect_in(3, "prio_idle", 8'h00, 1'b0, 1'b0);
    step(3);
    pulse_ss();
    step(6);
    expect_in(0, "pre_rst", 8'h03, 1'b1, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_in(0, "rst_mid",  8'h00, 1'b0, 1'b0);
    expect_in(4, "rst_idle", 8'h00, 1'b0, 1'b0);
    step(4);

`ifdef STOPWATCH_LAP_HOLD_EN
    pulse_ss();
    step(6);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    expect_in(0, "lap_snap", 8'h03, 1'b1, 1'b0);
    expect_in(7, "lap_hold", 8'h03, 1'b1, 1'b0);
    step(7);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    expect_in(0, "lap_release", 8'h07, 1'b1, 1'b0);
    step(1);
    pulse_clr();
`endif

    step(2);
    foreach (sb[i]) begin
      failures++;
      $display("FAIL %s: got no comparison at cycle %0d, want one", sb[i].name, sb[i].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
